// File: rtl/approx_region_cycle_timer.sv
// approx_region_cycle_timer
// Several timer channels. Each one records the cycle on which an approximate region starts
// and finishes on a stop event or on a timeout. Finished results leave through one
// registered valid/ready port, and the channels are served round-robin.
module approx_region_cycle_timer #(
  parameter int FETCH_WIDTH = 2,
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int DROP_W      = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic [CNT_WIDTH-1:0]        cycleCounter,
  input  logic                        flush,
  input  logic [FETCH_WIDTH-1:0]      startValid,
  input  logic [FETCH_WIDTH*CH_W-1:0] startCh,
  input  logic [FETCH_WIDTH-1:0]      stopValid,
  input  logic [FETCH_WIDTH*CH_W-1:0] stopCh,
  input  logic [CNT_WIDTH-1:0]        timeoutLimit,
  output logic                        resValid,
  input  logic                        resReady,
  output logic [CH_W-1:0]             resCh,
  output logic [CNT_WIDTH-1:0]        resBegin,
  output logic [CNT_WIDTH-1:0]        resElapsed,
  output logic                        resTimeout,
  output logic [NUM_CH-1:0]           busy,
  output logic [DROP_W-1:0]           dropCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_OUT  = 2'd3
  } ch_state_e;

  localparam logic [CH_W:0]     NUM_CH_EXT = (CH_W+1)'(NUM_CH);
  localparam logic [DROP_W-1:0] DROP_MAX   = '1;

  // Per-channel status and payload, flattened for the shared output logic
  logic [NUM_CH-1:0]           start_hit;
  logic [NUM_CH-1:0]           stop_hit;
  logic [NUM_CH-1:0]           idle_vec;
  logic [NUM_CH-1:0]           done_vec;
  logic [NUM_CH-1:0]           grant;
  logic [NUM_CH-1:0]           tmo_vec;
  logic [NUM_CH*CNT_WIDTH-1:0] begin_flat;
  logic [NUM_CH*CNT_WIDTH-1:0] elapsed_flat;

  // Output register stage and arbitration
  logic                 res_valid_reg, res_valid_next;
  logic [CH_W-1:0]      res_ch_reg, res_ch_next;
  logic [CNT_WIDTH-1:0] res_begin_reg, res_begin_next;
  logic [CNT_WIDTH-1:0] res_elapsed_reg, res_elapsed_next;
  logic                 res_tmo_reg, res_tmo_next;
  logic [CH_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic                 res_fire;
  logic                 load_en;
  logic [NUM_CH-1:0]    done_rot;
  logic                 grant_any;
  logic [CH_W-1:0]      grant_off;
  logic [CH_W:0]        grant_sum;
  logic [CH_W-1:0]      grant_idx;
  logic [CNT_WIDTH-1:0] sel_begin;
  logic [CNT_WIDTH-1:0] sel_elapsed;
  logic                 sel_tmo;

  // Dropped-start accounting
  logic [DROP_W-1:0] drop_count_reg, drop_count_next;
  logic [DROP_W:0]   drop_add;
  logic [DROP_W:0]   drop_sum;
  logic              lane_drop;

  assign res_fire = res_valid_reg && resReady;
  assign load_en  = !res_valid_reg || resReady;

  // Turn the lane events into per-channel hits. All lanes see the same cycleCounter,
  // so a lower lane winning gives the same begin value as any other lane would.
  always_comb begin
    start_hit = '0;
    stop_hit  = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (startValid[l] && startCh[l*CH_W +: CH_W] == CH_W'(c)) start_hit[c] = 1'b1;
        if (stopValid[l] && stopCh[l*CH_W +: CH_W] == CH_W'(c)) stop_hit[c] = 1'b1;
      end
    end
  end

  // Count the starts that are thrown away. A start is dropped if its channel is busy,
  // or if a lower lane targets the same channel. Starts in a flush cycle are not counted.
  always_comb begin
    drop_add  = '0;
    lane_drop = 1'b0;
    if (!flush) begin
      for (int l = 0; l < FETCH_WIDTH; l++) begin
        lane_drop = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (startCh[l*CH_W +: CH_W] == CH_W'(c) && !idle_vec[c]) lane_drop = 1'b1;
        end
        for (int j = 0; j < l; j++) begin
          if (startValid[j] && startCh[j*CH_W +: CH_W] == startCh[l*CH_W +: CH_W]) lane_drop = 1'b1;
        end
        if (startValid[l] && lane_drop) drop_add = drop_add + (DROP_W+1)'(1);
      end
    end
    drop_sum        = {1'b0, drop_count_reg} + drop_add;
    drop_count_next = drop_sum[DROP_W] ? DROP_MAX : drop_sum[DROP_W-1:0];
  end

  // Saturating dropped-start counter
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) drop_count_reg <= '0;
    else       drop_count_reg <= drop_count_next;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      ch_state_e            st_reg, st_next;
      logic [CNT_WIDTH-1:0] begin_reg, begin_next;
      logic [CNT_WIDTH-1:0] elapsed_reg, elapsed_next;
      logic                 tmo_reg, tmo_next;
      logic [CNT_WIDTH-1:0] run_len;
      logic                 timeout_hit;
      logic                 st_idle, st_done, st_busy;

      // The subtraction is modulo 2^CNT_WIDTH, so it stays correct when the counter wraps
      assign run_len     = cycleCounter - begin_reg;
      assign timeout_hit = (timeoutLimit != '0) && (run_len >= timeoutLimit);

      // Channel state and payload registers
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          st_reg      <= ST_IDLE;
          begin_reg   <= '0;
          elapsed_reg <= '0;
          tmo_reg     <= 1'b0;
        end else begin
          st_reg      <= st_next;
          begin_reg   <= begin_next;
          elapsed_reg <= elapsed_next;
          tmo_reg     <= tmo_next;
        end
      end

      // Next state: flush beats stop, and stop beats timeout
      always_comb begin
        st_next      = st_reg;
        begin_next   = begin_reg;
        elapsed_next = elapsed_reg;
        tmo_next     = tmo_reg;
        case (st_reg)
          ST_IDLE: begin
            if (start_hit[gi] && !flush) begin
              st_next    = ST_RUN;
              begin_next = cycleCounter;
            end
          end
          ST_RUN: begin
            if (flush) begin
              st_next = ST_IDLE;
            end else if (stop_hit[gi]) begin
              st_next      = ST_DONE;
              elapsed_next = run_len;
              tmo_next     = 1'b0;
            end else if (timeout_hit) begin
              st_next      = ST_DONE;
              elapsed_next = timeoutLimit;
              tmo_next     = 1'b1;
            end
          end
          ST_DONE: begin
            if (grant[gi]) st_next = ST_OUT;
          end
          ST_OUT: begin
            if (res_fire && res_ch_reg == CH_W'(gi)) st_next = ST_IDLE;
          end
          default: st_next = ST_IDLE;
        endcase
      end

      // Status decoded from the state
      always_comb begin
        st_idle = (st_reg == ST_IDLE);
        st_done = (st_reg == ST_DONE);
        st_busy = !st_idle;
      end

      assign idle_vec[gi] = st_idle;
      assign done_vec[gi] = st_done;
      assign busy[gi]     = st_busy;
      assign tmo_vec[gi]  = tmo_reg;
      assign begin_flat[gi*CNT_WIDTH +: CNT_WIDTH]   = begin_reg;
      assign elapsed_flat[gi*CNT_WIDTH +: CNT_WIDTH] = elapsed_reg;
    end
  endgenerate

  // Rotate the DONE vector so that bit 0 is the channel the round-robin pointer names
  assign done_rot = NUM_CH'({done_vec, done_vec} >> rr_ptr_reg);

  // Round-robin pick: the first DONE channel at or after the pointer
  always_comb begin
    grant_any = 1'b0;
    grant_off = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (done_rot[k]) begin
        grant_any = 1'b1;
        grant_off = CH_W'(k);
      end
    end
    grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
    grant_idx = (grant_sum >= NUM_CH_EXT) ? CH_W'(grant_sum - NUM_CH_EXT) : grant_sum[CH_W-1:0];
    grant     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_idx == CH_W'(c)) grant[c] = load_en && grant_any;
    end
  end

  // Select the payload of the granted channel
  always_comb begin
    sel_begin   = '0;
    sel_elapsed = '0;
    sel_tmo     = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_idx == CH_W'(c)) begin
        sel_begin   = begin_flat[c*CNT_WIDTH +: CNT_WIDTH];
        sel_elapsed = elapsed_flat[c*CNT_WIDTH +: CNT_WIDTH];
        sel_tmo     = tmo_vec[c];
      end
    end
  end

  // Output stage: reload when empty or draining; the payload holds under backpressure
  always_comb begin
    res_valid_next   = res_valid_reg;
    res_ch_next      = res_ch_reg;
    res_begin_next   = res_begin_reg;
    res_elapsed_next = res_elapsed_reg;
    res_tmo_next     = res_tmo_reg;
    rr_ptr_next      = rr_ptr_reg;
    if (load_en) begin
      res_valid_next = grant_any;
      if (grant_any) begin
        res_ch_next      = grant_idx;
        res_begin_next   = sel_begin;
        res_elapsed_next = sel_elapsed;
        res_tmo_next     = sel_tmo;
        rr_ptr_next      = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      res_valid_reg   <= 1'b0;
      res_ch_reg      <= '0;
      res_begin_reg   <= '0;
      res_elapsed_reg <= '0;
      res_tmo_reg     <= 1'b0;
      rr_ptr_reg      <= '0;
    end else begin
      res_valid_reg   <= res_valid_next;
      res_ch_reg      <= res_ch_next;
      res_begin_reg   <= res_begin_next;
      res_elapsed_reg <= res_elapsed_next;
      res_tmo_reg     <= res_tmo_next;
      rr_ptr_reg      <= rr_ptr_next;
    end
  end

  assign resValid   = res_valid_reg;
  assign resCh      = res_ch_reg;
  assign resBegin   = res_begin_reg;
  assign resElapsed = res_elapsed_reg;
  assign resTimeout = res_tmo_reg;
  assign dropCount  = drop_count_reg;

endmodule

// File: tb/tb_approx_region_cycle_timer.sv
// Testbench for approx_region_cycle_timer. It runs directed scenarios with literal
// expectations, then random traffic checked on every cycle against a behavioural model.
module tb_approx_region_cycle_timer;
  localparam int FW  = 2;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int DW  = 16;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rstN;
  logic [CW-1:0]     cycleCounter;
  logic              flush;
  logic [FW-1:0]     startValid;
  logic [FW*CHW-1:0] startCh;
  logic [FW-1:0]     stopValid;
  logic [FW*CHW-1:0] stopCh;
  logic [CW-1:0]     timeoutLimit;
  logic              resValid;
  logic              resReady;
  logic [CHW-1:0]    resCh;
  logic [CW-1:0]     resBegin;
  logic [CW-1:0]     resElapsed;
  logic              resTimeout;
  logic [NCH-1:0]    busy;
  logic [DW-1:0]     dropCount;

  always #5 clk = ~clk;

  approx_region_cycle_timer #(
    .FETCH_WIDTH(FW), .NUM_CH(NCH), .CNT_WIDTH(CW), .DROP_W(DW)
  ) dut (
    .clk(clk), .rstN(rstN), .cycleCounter(cycleCounter), .flush(flush),
    .startValid(startValid), .startCh(startCh), .stopValid(stopValid), .stopCh(stopCh),
    .timeoutLimit(timeoutLimit), .resValid(resValid), .resReady(resReady), .resCh(resCh),
    .resBegin(resBegin), .resElapsed(resElapsed), .resTimeout(resTimeout),
    .busy(busy), .dropCount(dropCount)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model. Phase codes: 0 idle, 1 running, 2 finished, 3 presented at the output.
  int        m_ph[NCH];
  bit [31:0] m_beg[NCH];
  bit [31:0] m_ela[NCH];
  bit        m_tmo[NCH];
  bit        m_valid;
  int        m_ch;
  bit [31:0] m_obeg;
  bit [31:0] m_oela;
  bit        m_otmo;
  int        m_rr;
  int        m_drops;
  logic [NCH-1:0] exp_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = 0; m_beg[c] = 0; m_ela[c] = 0; m_tmo[c] = 0;
    end
    m_valid = 0; m_ch = 0; m_obeg = 0; m_oela = 0; m_otmo = 0; m_rr = 0; m_drops = 0;
  endtask

  // Apply one clock edge's worth of the rules to the model, using the inputs the DUT just sampled
  task automatic model_step();
    int        nph[NCH];
    bit [31:0] nbeg[NCH];
    bit [31:0] nela[NCH];
    bit        ntmo[NCH];
    bit        hs;
    bit        load;
    bit        found;
    for (int c = 0; c < NCH; c++) begin
      nph[c] = m_ph[c]; nbeg[c] = m_beg[c]; nela[c] = m_ela[c]; ntmo[c] = m_tmo[c];
    end
    hs   = m_valid && resReady;
    load = !m_valid || resReady;
    for (int c = 0; c < NCH; c++) begin
      bit        sh;
      bit        sp;
      bit [31:0] len;
      sh = 0; sp = 0;
      for (int l = 0; l < FW; l++) begin
        if (startValid[l] && int'(startCh[l*CHW +: CHW]) == c) sh = 1;
        if (stopValid[l] && int'(stopCh[l*CHW +: CHW]) == c) sp = 1;
      end
      len = cycleCounter - m_beg[c];
      if (m_ph[c] == 0) begin
        if (sh && !flush) begin nph[c] = 1; nbeg[c] = cycleCounter; end
      end else if (m_ph[c] == 1) begin
        if (flush) nph[c] = 0;
        else if (sp) begin nph[c] = 2; nela[c] = len; ntmo[c] = 0; end
        else if (timeoutLimit != 0 && len >= timeoutLimit) begin
          nph[c] = 2; nela[c] = timeoutLimit; ntmo[c] = 1;
        end
      end else if (m_ph[c] == 3) begin
        if (hs && m_ch == c) nph[c] = 0;
      end
    end
    if (!flush) begin
      for (int l = 0; l < FW; l++) begin
        if (startValid[l]) begin
          int t;
          bit bad;
          t = int'(startCh[l*CHW +: CHW]);
          bad = (m_ph[t] != 0);
          for (int j = 0; j < l; j++)
            if (startValid[j] && int'(startCh[j*CHW +: CHW]) == t) bad = 1;
          if (bad && m_drops < 65535) m_drops++;
        end
      end
    end
    if (load) begin
      found = 0;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_rr + k) % NCH;
        if (!found && m_ph[c] == 2) begin
          found = 1;
          m_ch = c; m_obeg = m_beg[c]; m_oela = m_ela[c]; m_otmo = m_tmo[c];
          nph[c] = 3;
          m_rr = (c + 1) % NCH;
        end
      end
      m_valid = found;
    end
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = nph[c]; m_beg[c] = nbeg[c]; m_ela[c] = nela[c]; m_tmo[c] = ntmo[c];
    end
  endtask

  // Advance one clock: the DUT samples the inputs, the model follows, then the counter moves on
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rstN) model_reset();
    else model_step();
    cycleCounter = cycleCounter + 1;
  endtask

  task automatic idle_inputs();
    flush = 0; startValid = 0; startCh = 0; stopValid = 0; stopCh = 0;
  endtask

  // Compare the DUT outputs with the model on every cycle, away from the active edge
  always @(negedge clk) begin
    if (rstN === 1'b1 && cmp_en) begin
      for (int c = 0; c < NCH; c++) exp_busy[c] = (m_ph[c] != 0);
      chk("resValid", resValid, m_valid);
      chk("busy", busy, exp_busy);
      chk("dropCount", dropCount, m_drops);
      if (m_valid) begin
        chk("resCh", resCh, m_ch);
        chk("resBegin", resBegin, m_obeg);
        chk("resElapsed", resElapsed, m_oela);
        chk("resTimeout", resTimeout, m_otmo);
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstN = 0; cycleCounter = 0; timeoutLimit = 0; resReady = 1;
    idle_inputs();
    model_reset();

    // Reset held with events on every lane
    for (int i = 0; i < 4; i++) begin
      startValid = 2'b11; startCh = 4'(i * 5); stopValid = 2'b11; stopCh = 4'(i * 3); flush = 0;
      cycle();
    end
    idle_inputs();
    rstN = 1;
    chk("rst_resValid", resValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropCount", dropCount, 0);
    chk("rst_payload", {resCh, resBegin, resElapsed, resTimeout}, 0);
    cmp_en = 1;

    // Start ch1 at 100, stop at 137
    cycleCounter = 100; startValid = 2'b01; startCh = {2'd0, 2'd1};
    cycle(); idle_inputs();
    while (cycleCounter != 137) cycle();
    stopValid = 2'b10; stopCh = {2'd1, 2'd0};
    cycle(); idle_inputs();
    chk("t2_valid_early", resValid, 0);
    chk("t2_busy1", busy[1], 1);
    cycle();
    chk("t2_valid", resValid, 1);
    chk("t2_ch", resCh, 1);
    chk("t2_begin", resBegin, 100);
    chk("t2_elapsed", resElapsed, 37);
    chk("t2_timeout", resTimeout, 0);
    chk("t2_model_elapsed", m_oela, 37);
    cycle();
    chk("t2_busy1_clear", busy[1], 0);

    // Counter wrap
    cycleCounter = 32'hFFFF_FFF0; startValid = 2'b01; startCh = {2'd0, 2'd0};
    cycle(); idle_inputs();
    cycleCounter = 32'h0000_0010; stopValid = 2'b01; stopCh = {2'd0, 2'd0};
    cycle(); idle_inputs();
    cycle();
    chk("t3_ch", resCh, 0);
    chk("t3_begin", resBegin, 32'hFFFF_FFF0);
    chk("t3_elapsed", resElapsed, 32'h20);
    cycle();

    // Timeout
    timeoutLimit = 8; cycleCounter = 50; startValid = 2'b01; startCh = {2'd0, 2'd2};
    cycle(); idle_inputs();
    n = 0;
    while (resValid !== 1'b1 && n < 20) begin cycle(); n++; end
    chk("t4_seen", resValid, 1);
    chk("t4_out_counter", cycleCounter - 1, 59);
    chk("t4_ch", resCh, 2);
    chk("t4_begin", resBegin, 50);
    chk("t4_elapsed", resElapsed, 8);
    chk("t4_timeout", resTimeout, 1);
    cycle();
    timeoutLimit = 0;

    // Conflicts and flush
    cycleCounter = 200; startValid = 2'b11; startCh = {2'd3, 2'd3};
    cycle(); idle_inputs();
    chk("t5_drop1", dropCount, 1);
    chk("t5_busy3", busy[3], 1);
    startValid = 2'b10; startCh = {2'd3, 2'd0};
    cycle(); idle_inputs();
    chk("t5_drop2", dropCount, 2);
    flush = 1; startValid = 2'b11; startCh = {2'd3, 2'd0};
    cycle(); idle_inputs();
    chk("t5_flush_busy", busy, 0);
    chk("t5_flush_drop", dropCount, 2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_no_result", resValid, 0);
    end

    // Arbitration under backpressure
    cycleCounter = 300; startValid = 2'b11; startCh = {2'd1, 2'd0};
    cycle(); idle_inputs();
    startValid = 2'b01; startCh = {2'd0, 2'd2};
    cycle(); idle_inputs();
    cycle(); cycle();
    resReady = 0; stopValid = 2'b11; stopCh = {2'd1, 2'd0};
    cycle(); idle_inputs();
    stopValid = 2'b01; stopCh = {2'd0, 2'd2};
    cycle(); idle_inputs();
    chk("t6_first_valid", resValid, 1);
    chk("t6_first_ch", resCh, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t6_hold_ch", resCh, 0);
      chk("t6_hold_begin", resBegin, 300);
      chk("t6_hold_busy", busy, 4'b0111);
    end
    resReady = 1;
    cycle();
    chk("t6_ch1", resCh, 1);
    chk("t6_busy_a", busy, 4'b0110);
    cycle();
    chk("t6_ch2", resCh, 2);
    chk("t6_begin2", resBegin, 301);
    chk("t6_busy_b", busy, 4'b0100);
    cycle();
    chk("t6_empty", resValid, 0);
    chk("t6_busy_c", busy, 0);

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      if (it % 200 == 0) timeoutLimit = ($urandom_range(0, 2) == 0) ? 0 : 32'($urandom_range(1, 24));
      if (it % 500 == 250) cycleCounter = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      startValid = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      startCh    = 4'($urandom_range(0, 15));
      stopValid  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      stopCh     = 4'($urandom_range(0, 15));
      flush      = ($urandom_range(0, 39) == 0);
      resReady   = ($urandom_range(0, 9) < 7);
      cycle();
      if (it == 1500) begin
        rstN = 0;
        cycle(); cycle();
        idle_inputs();
        rstN = 1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", resValid, 0);
        chk("mid_rst_drop", dropCount, 0);
      end
    end

    // Drive the dropped counter into saturation
    idle_inputs(); timeoutLimit = 0; resReady = 1; flush = 1;
    cycle(); idle_inputs();
    for (int i = 0; i < 10; i++) cycle();
    chk("sat_idle", busy, 0);
    startValid = 2'b11; startCh = {2'd1, 2'd0};
    cycle();
    startCh = {2'd3, 2'd2};
    cycle();
    chk("sat_all_run", busy, 4'b1111);
    startCh = {2'd1, 2'd2};
    for (int i = 0; i < 33000; i++) cycle();
    chk("sat_value", dropCount, 16'hFFFF);
    idle_inputs(); flush = 1;
    cycle(); idle_inputs();
    cycle();
    chk("sat_flush_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
